// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, HI/LO registers, single-cycle multiply
// and an iterative restoring divider that stalls the pipeline while busy.
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop,
    input  logic [2:0]  ex_alusel,
    input  logic [31:0] ex_opv1,
    input  logic [31:0] ex_opv2,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic        stall_req
);

    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2,
                           SEL_ARITH = 3'd3, SEL_MOVE = 3'd4, SEL_MULDIV = 3'd5;

    localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27,
                           OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03,
                           OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B,
                           OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13,
                           OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t    state, state_nxt;
    logic [31:0]   hi, lo;
    logic [CW-1:0] cnt;
    logic [31:0]   dq, dr, dd;
    logic          neg_q, neg_r;

    logic [31:0] result;
    logic [63:0] prod_s, prod_u;
    logic        div_op, div_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] diff;

    assign prod_s = {{32{ex_opv1[31]}}, ex_opv1} * {{32{ex_opv2[31]}}, ex_opv2};
    assign prod_u = {32'b0, ex_opv1} * {32'b0, ex_opv2};

    assign div_op     = (ex_alusel == SEL_MULDIV) && (ex_aluop == OP_DIV || ex_aluop == OP_DIVU);
    assign div_signed = (ex_aluop == OP_DIV);
    assign a_mag      = (div_signed && ex_opv1[31]) ? 32'd0 - ex_opv1 : ex_opv1;
    assign b_mag      = (div_signed && ex_opv2[31]) ? 32'd0 - ex_opv2 : ex_opv2;

    // Partial remainder stays below the divisor, so the difference fits 32 bits.
    assign rem_sh = {dr, dq[31]};
    assign ge     = rem_sh >= {1'b0, dd};
    assign diff   = rem_sh[31:0] - dd;

    always_comb begin
        result = '0;
        case (ex_alusel)
            SEL_LOGIC: case (ex_aluop)
                OP_AND:  result = ex_opv1 & ex_opv2;
                OP_OR:   result = ex_opv1 | ex_opv2;
                OP_XOR:  result = ex_opv1 ^ ex_opv2;
                OP_NOR:  result = ~(ex_opv1 | ex_opv2);
                default: result = '0;
            endcase
            SEL_SHIFT: case (ex_aluop)
                OP_SLL:  result = ex_opv2 << ex_opv1[4:0];
                OP_SRL:  result = ex_opv2 >> ex_opv1[4:0];
                OP_SRA:  result = $signed(ex_opv2) >>> ex_opv1[4:0];
                default: result = '0;
            endcase
            SEL_ARITH: case (ex_aluop)
                OP_ADDU: result = ex_opv1 + ex_opv2;
                OP_SUBU: result = ex_opv1 - ex_opv2;
                OP_SLT:  result = {31'b0, $signed(ex_opv1) < $signed(ex_opv2)};
                OP_SLTU: result = {31'b0, ex_opv1 < ex_opv2};
                default: result = '0;
            endcase
            SEL_MOVE: case (ex_aluop)
                OP_MFHI: result = hi;
                OP_MFLO: result = lo;
                default: result = '0;
            endcase
            default: result = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        case (state)
            IDLE: if (div_op && !rst) begin
                stall_req = 1'b1;
                state_nxt = (ex_opv2 == '0) ? DONE : BUSY;
            end
            BUSY: begin
                stall_req = 1'b1;
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            dq    <= '0;
            dr    <= '0;
            dd    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (div_op) begin
                        // Zero divisor preloads the fixed result so DONE needs no special case.
                        if (ex_opv2 == '0) begin
                            dq    <= '1;
                            dr    <= ex_opv1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            dq    <= a_mag;
                            dr    <= '0;
                            dd    <= b_mag;
                            neg_q <= div_signed && (ex_opv1[31] ^ ex_opv2[31]);
                            neg_r <= div_signed && ex_opv1[31];
                            cnt   <= CW'(DIV_CYCLES);
                        end
                    end else if (ex_alusel == SEL_MOVE && ex_aluop == OP_MTHI) begin
                        hi <= ex_opv1;
                    end else if (ex_alusel == SEL_MOVE && ex_aluop == OP_MTLO) begin
                        lo <= ex_opv1;
                    end else if (ex_alusel == SEL_MULDIV && ex_aluop == OP_MULT) begin
                        {hi, lo} <= prod_s;
                    end else if (ex_alusel == SEL_MULDIV && ex_aluop == OP_MULTU) begin
                        {hi, lo} <= prod_u;
                    end
                end
                BUSY: begin
                    dq  <= {dq[30:0], ge};
                    dr  <= ge ? diff : rem_sh[31:0];
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    lo <= neg_q ? 32'd0 - dq : dq;
                    hi <= neg_r ? 32'd0 - dr : dr;
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = result;
    assign mem_we    = ex_we & ~stall_req;
    assign mem_waddr = ex_waddr;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, directed multi-cycle divide/reset
// sequences, and randomized instructions against an arithmetic reference model.
module tb_ex_stage;

    localparam int unsigned DIV_CYCLES = 32;

    localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2, S_AR = 3'd3,
                           S_MV = 3'd4, S_MD = 3'd5;
    localparam logic [7:0] AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26, NOR_ = 8'h27,
                           SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03, ADDU = 8'h21, SUBU = 8'h23,
                           SLT = 8'h2A, SLTU = 8'h2B, MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12,
                           MTLO = 8'h13, MULT = 8'h18, MULTU = 8'h19, DIV = 8'h1A, DIVU = 8'h1B;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_opv1, ex_opv2;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic        stall_req;

    always #5 clk = ~clk;

    ex_stage #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_opv1(ex_opv1), .ex_opv2(ex_opv2), .ex_we(ex_we), .ex_waddr(ex_waddr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_waddr(mem_waddr), .stall_req(stall_req)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] sel, input logic [7:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        if (sel == S_NOP) return '0;
        case (op)
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            NOR_: return ~(a | b);
            SLL:  return b << a[4:0];
            SRL:  return b >> a[4:0];
            SRA: begin
                ext = {{32{b[31]}}, b} >> a[4:0];
                return ext[31:0];
            end
            ADDU: return a + b;
            SUBU: return a - b;
            SLT:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            SLTU: return (a < b) ? 32'd1 : 32'd0;
            MFHI: return m_hi;
            MFLO: return m_lo;
            default: return '0;
        endcase
    endfunction

    task automatic set_in(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic we, input logic [4:0] wa);
        ex_alusel = sel; ex_aluop = op; ex_opv1 = a; ex_opv2 = b; ex_we = we; ex_waddr = wa;
    endtask

    // Single-cycle instruction: called and returns at 1 time unit after a rising edge.
    task automatic exec(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic we, input logic [4:0] wa,
                        input logic [31:0] exp, input string name);
        longint p;
        logic [63:0] pu;
        set_in(sel, op, a, b, we, wa);
        @(negedge clk);
        check32({name, " wdata"}, mem_wdata, exp);
        check32({name, " we"}, {31'b0, mem_we}, {31'b0, we});
        check32({name, " waddr"}, {27'b0, mem_waddr}, {27'b0, wa});
        check32({name, " stall"}, {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        if (sel == S_MV && op == MTHI) m_hi = a;
        if (sel == S_MV && op == MTLO) m_lo = a;
        if (sel == S_MD && op == MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {m_hi, m_lo} = p;
        end
        if (sel == S_MD && op == MULTU) begin
            pu = {32'b0, a} * {32'b0, b};
            {m_hi, m_lo} = pu;
        end
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic scramble, input string name);
        int n;
        longint sa, sb;
        n = 0;
        set_in(S_MD, sgn ? DIV : DIVU, a, b, 1'b1, 5'd9);
        @(negedge clk);
        check32({name, " we_stalled"}, {31'b0, mem_we}, 32'd0);
        while (stall_req === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            if (scramble && n >= 2 && stall_req === 1'b1) begin
                ex_opv1 = $urandom; ex_opv2 = $urandom;
            end
        end
        checkn({name, " stall_cycles"}, n, (b == 0) ? 1 : int'(DIV_CYCLES) + 1);
        check32({name, " done_we"}, {31'b0, mem_we}, 32'd1);
        check32({name, " done_wdata"}, mem_wdata, 32'd0);
        @(posedge clk); #1;
        if (b == 0) begin
            m_lo = '1; m_hi = a;
        end else if (sgn) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
        end else begin
            m_lo = a / b; m_hi = a % b;
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a, b;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{S_AR,  ADDU, 32'h7FFF_FFFF, 32'h1,         1'b1, 5'd3,  32'h8000_0000};
        vecs[1]  = '{S_SH,  SRA,  32'h4,         32'hF000_0000, 1'b1, 5'd4,  32'hFF00_0000};
        vecs[2]  = '{S_AR,  SLT,  32'hFFFF_FFFF, 32'h1,         1'b1, 5'd5,  32'h1};
        vecs[3]  = '{S_AR,  SLTU, 32'hFFFF_FFFF, 32'h1,         1'b0, 5'd6,  32'h0};
        vecs[4]  = '{S_AR,  SLT,  32'h1,         32'hFFFF_FFFF, 1'b1, 5'd7,  32'h0};
        vecs[5]  = '{S_LOG, AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 5'd8,  32'h00F0_1234};
        vecs[6]  = '{S_LOG, OR_,  32'hF000_0000, 32'h0000_000F, 1'b1, 5'd9,  32'hF000_000F};
        vecs[7]  = '{S_LOG, XOR_, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 5'd10, 32'hF0F0_0F0F};
        vecs[8]  = '{S_LOG, NOR_, 32'h0000_00FF, 32'h0000_FF00, 1'b1, 5'd11, 32'hFFFF_0000};
        vecs[9]  = '{S_SH,  SLL,  32'hFFFF_FFE4, 32'h0000_0001, 1'b1, 5'd12, 32'h0000_0010};
        vecs[10] = '{S_SH,  SRL,  32'd31,        32'h8000_0000, 1'b1, 5'd13, 32'h1};
        vecs[11] = '{S_AR,  SUBU, 32'h0,         32'h1,         1'b1, 5'd14, 32'hFFFF_FFFF};
        vecs[12] = '{S_LOG, 8'h55, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd15, 32'h0};
        vecs[13] = '{S_NOP, 8'h00, 32'h1234_5678, 32'h1,        1'b1, 5'd16, 32'h0};
        vecs[14] = '{S_SH,  SRA,  32'd0,         32'h8000_0001, 1'b1, 5'd31, 32'h8000_0001};

        rst = 1'b1;
        set_in(S_NOP, 8'h00, '0, '0, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;

        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'h0, "reset_hi");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd2, 32'h0, "reset_lo");

        for (int i = 0; i < 15; i++)
            exec(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].wa,
                 vecs[i].exp, $sformatf("vec%0d", i));

        exec(S_MD, MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd1, 32'h0, "mult");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'hFFFF_FFFF, "mult_hi");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'hFFFF_FFFA, "mult_lo");

        exec(S_MV, MTHI, 32'hDEAD_BEEF, '0, 1'b0, 5'd0, 32'h0, "mthi");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'hDEAD_BEEF, "mthi_rd");

        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'hFFFF_FFFD, "div_m7_2 lo");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'hFFFF_FFFF, "div_m7_2 hi");

        do_div(1'b0, 32'd7, 32'd0, 1'b0, "divu_7_0");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'hFFFF_FFFF, "divu_7_0 lo");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'd7, "divu_7_0 hi");

        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'h8000_0000, "div_min lo");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'h0, "div_min hi");

        // Reset during the tenth BUSY cycle abandons the divide.
        exec(S_MV, MTLO, 32'h5555_AAAA, '0, 1'b0, 5'd0, 32'h0, "mtlo");
        set_in(S_MD, DIV, 32'd100, 32'd7, 1'b1, 5'd2);
        @(negedge clk);
        check32("rstbusy stall_idle", {31'b0, stall_req}, 32'd1);
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(S_NOP, 8'h00, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check32("rstbusy stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        m_hi = '0; m_lo = '0;
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'h0, "rstbusy hi");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'h0, "rstbusy lo");
        do_div(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'd14, "divu_100_7 lo");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'd2, "divu_100_7 hi");

        // Back-to-back divides: the second must stall from its very first cycle.
        do_div(1'b0, 32'd9, 32'd2, 1'b0, "b2b_first");
        check32("b2b_first lo", dut.lo, 32'd4);
        check32("b2b_first hi", dut.hi, 32'd1);
        do_div(1'b0, 32'd20, 32'd6, 1'b0, "b2b_second");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, 32'd3, "b2b lo");
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, 32'd2, "b2b hi");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            logic [2:0]  sel;
            logic [7:0]  op;
            logic        we;
            logic [4:0]  wa;
            a = rnd_val(); b = rnd_val();
            we = 1'($urandom_range(0, 1)); wa = 5'($urandom);
            case ($urandom_range(0, 20))
                0:  begin sel = S_LOG; op = AND_;  end
                1:  begin sel = S_LOG; op = OR_;   end
                2:  begin sel = S_LOG; op = XOR_;  end
                3:  begin sel = S_LOG; op = NOR_;  end
                4:  begin sel = S_SH;  op = SLL;   end
                5:  begin sel = S_SH;  op = SRL;   end
                6:  begin sel = S_SH;  op = SRA;   end
                7:  begin sel = S_AR;  op = ADDU;  end
                8:  begin sel = S_AR;  op = SUBU;  end
                9:  begin sel = S_AR;  op = SLT;   end
                10: begin sel = S_AR;  op = SLTU;  end
                11: begin sel = S_MV;  op = MFHI;  end
                12: begin sel = S_MV;  op = MFLO;  end
                13: begin sel = S_MV;  op = MTHI;  end
                14: begin sel = S_MV;  op = MTLO;  end
                15: begin sel = S_MD;  op = MULT;  end
                16: begin sel = S_MD;  op = MULTU; end
                17: begin sel = S_MD;  op = ($urandom_range(0, 1) == 0) ? DIV : DIVU; end
                18: begin sel = S_MV;  op = MFHI;  end
                19: begin sel = S_MV;  op = MFLO;  end
                default: begin sel = S_NOP; op = 8'($urandom); end
            endcase
            if (sel == S_MD && (op == DIV || op == DIVU))
                do_div(op == DIV, a, b, 1'b1, $sformatf("rnd%0d div", i));
            else
                exec(sel, op, a, b, we, wa, model_res(sel, op, a, b), $sformatf("rnd%0d", i));
        end
        exec(S_MV, MFHI, '0, '0, 1'b1, 5'd1, m_hi, "final hi");
        exec(S_MV, MFLO, '0, '0, 1'b1, 5'd1, m_lo, "final lo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of BUSY iterations of the divider (one quotient bit per cycle).
REQ-002 SHALL have ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_aluop  in  8  operation code from the ID/EX register.
- ex_alusel  in  3  operation class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MOVE, 5 MULDIV.
- ex_opv1  in  32  operand 1 (shift amount in [4:0] for SHIFT).
- ex_opv2  in  32  operand 2.
- ex_we  in  1  register-file write enable from decode.
- ex_waddr  in  5  register-file write address.
- mem_wdata  out  32  result to the MEM-stage register.
- mem_we  out  1  write enable to the MEM-stage register.
- mem_waddr  out  5  equals ex_waddr.
- stall_req  out  1  request to hold PC, IF/ID and ID/EX and bubble EX/MEM.

Function
REQ-003 SHALL decode these aluop codes: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B; any other code yields mem_wdata=0.
REQ-004 SHALL compute LOGIC, SHIFT, ARITH and MFHI/MFLO results combinationally from the current inputs: shifts use opv2 as the value and opv1[4:0] as the amount; ADDU/SUBU wrap mod 2^32; SLT is a signed compare and SLTU an unsigned compare, each giving 0 or 1.
REQ-005 SHALL hold internal 32-bit HI and LO registers.
- MTHI: HI<=opv1.
- MTLO: LO<=opv1.
- MULT/MULTU: {HI,LO} <= the signed/unsigned 64-bit product, single cycle.
- The write SHALL occur at the rising edge that ends the instruction's EX cycle.
REQ-006 SHALL read HI/LO for MFHI/MFLO as the register value; a MULT/MTHI/MTLO/DIV in the preceding instruction is visible because its write has already committed.
REQ-007 SHALL drive mem_we = ex_we AND NOT stall_req, and mem_wdata=0 for NOP, MTHI, MTLO and the MULDIV class.
REQ-008 SHALL implement DIV/DIVU with an FSM of states IDLE, BUSY and DONE.
- IDLE with DIV/DIVU and opv2!=0: latch the operand magnitudes and the signs, load the counter with DIV_CYCLES, assert stall_req, go to BUSY.
- IDLE with DIV/DIVU and opv2==0: assert stall_req and go directly to DONE.
- BUSY: one restoring-division step per cycle, decrement the counter, keep stall_req=1; when the counter reaches 1, go to DONE.
- DONE: stall_req=0; at the edge, LO<=quotient, HI<=remainder, go to IDLE.
REQ-009 SHALL give a total stall of DIV_CYCLES+1 cycles for a nonzero divisor, and 1 cycle for a zero divisor.
REQ-010 SHALL apply signed-division sign rules: quotient sign = sign(opv1) XOR sign(opv2), remainder sign = sign(opv1); 0x80000000 DIV 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-011 SHALL give LO=0xFFFFFFFF, HI=opv1 for division by zero, for both DIV and DIVU.
REQ-012 SHALL treat the operands latched in IDLE as authoritative while BUSY and ignore input changes until DONE.
REQ-013 SHALL handle back-to-back DIV instructions: the second is accepted in IDLE on the cycle after DONE, with no lost or merged result.
REQ-014 SHALL keep stall_req=0 in IDLE for all non-divide operations.

Reset
REQ-015 SHALL, with rst=1 at a rising edge, set HI=0, LO=0, FSM=IDLE, counter=0 and all divider datapath registers to 0; stall_req=0 follows in the same cycle the reset takes effect.
REQ-016 SHALL, on reset while BUSY, abandon the division with no HI/LO write, and SHALL perform no HI/LO writes while rst=1.

Verification
REQ-017 SHALL be covered by these directed bench scenarios:
- ADDU 0x7FFFFFFF+1, we=1, waddr=3 -> mem_wdata=0x80000000, mem_we=1, mem_waddr=3, same cycle.
- SRA opv1=4, opv2=0xF0000000 -> 0xFF000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU 0xFFFFFFFF vs 1 -> 0.
- MULT 0xFFFFFFFE x 3, then MFHI, then MFLO -> 0xFFFFFFFF, then 0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> stall_req high 33 cycles, then MFLO=0xFFFFFFFD, MFHI=0xFFFFFFFF; DIVU 7/0 -> 1 stall cycle, LO=0xFFFFFFFF, HI=7.
- DIV 100/7, rst pulsed on BUSY cycle 10 -> stall_req=0, HI=LO=0 after reset; a following DIVU 100/7 gives LO=14, HI=2.
- Two consecutive DIVU (9/2, 20/6) -> LO=4, HI=1, then LO=3, HI=2; stall_req low for exactly one cycle between them.
